// File: rtl/spi_frame_responder.sv
// -----------------------------------------------------------------------------
// spi_frame_responder
//
// Slave-side frame decoder for the sensor-frame SPI master. It sits behind a
// byte-level SPI slave core and decodes master-initiated frames.
//
// Write frame : WRITE_OPCODE, BUF_ADDRESS, then NUM_SENSORS 32-bit values sent
//               LSB-first. Each completed value is strobed out on
//               sensor_valid with its 0-based index.
// Read frame  : READ_OPCODE, then four bytes clocked out MSB-first from a
//               snapshot of command_in taken when the opcode byte arrives.
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   cs_n         in   chip select (already synchronised), low = frame active
//   rx_valid     in   one-cycle strobe, rx_byte holds a completed byte
//   rx_byte      in   received byte
//   tx_req       in   level, core requests the next transmit byte
//   tx_byte      out  byte to transmit
//   tx_wren      out  one-cycle strobe loading tx_byte into the core
//   command_in   in   command word returned on read frames
//   sensor_value out  assembled sensor value
//   sensor_index out  index of sensor_value
//   sensor_valid out  one-cycle strobe, sensor_value/sensor_index valid
//   frame_done   out  one-cycle strobe, a complete legal frame ended
//   frame_error  out  one-cycle strobe, an illegal/short/overlong frame ended
// -----------------------------------------------------------------------------
module spi_frame_responder #(
  parameter int         NUM_SENSORS  = 8,
  parameter logic [7:0] WRITE_OPCODE = 8'h02,
  parameter logic [7:0] READ_OPCODE  = 8'h00,
  parameter logic [7:0] BUF_ADDRESS  = 8'h00
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cs_n,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  input  logic                           tx_req,
  output logic [7:0]                     tx_byte,
  output logic                           tx_wren,
  input  logic [31:0]                    command_in,
  output logic [31:0]                    sensor_value,
  output logic [$clog2(NUM_SENSORS)-1:0] sensor_index,
  output logic                           sensor_valid,
  output logic                           frame_done,
  output logic                           frame_error
);

  localparam int FRAME_LEN = 2 + 4 * NUM_SENSORS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int IDX_W     = $clog2(NUM_SENSORS);

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_READ  = CNT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_DISCARD
  } state_t;

  // Counters stop one past a full frame so "too long" stays distinguishable
  // from "exactly right" without needing a wider register.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic             r_cs_n_d;
  logic [CNT_W-1:0] r_rx_count;
  logic [CNT_W-1:0] r_tx_count;
  logic             r_overflow;
  logic [23:0]      r_word;      // lanes 0..2; lane 3 completes the word directly
  logic [31:0]      r_shadow;
  logic [31:0]      r_sensor_value;
  logic [IDX_W-1:0] r_sensor_index;
  logic             r_sensor_valid;
  logic             r_frame_done;
  logic             r_frame_error;
  logic [7:0]       r_tx_byte;
  logic             r_tx_wren;
  logic             r_tx_served;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic [CNT_W-1:0] w_d;
  state_t           w_state_nxt;
  state_t           w_state_dec;
  logic [CNT_W-1:0] w_rx_count_nxt;
  logic             w_overflow_nxt;
  logic [23:0]      w_word_nxt;
  logic             w_emit;
  logic [31:0]      w_emit_value;
  logic [IDX_W-1:0] w_emit_idx;
  logic             w_snap;
  logic             w_done;
  logic             w_err;

  logic [CNT_W-1:0] w_tx_base;
  logic [CNT_W-1:0] w_rx_base;
  logic             w_in_frame;
  logic             w_tx_ready;
  logic             w_tx_serve;
  logic [7:0]       w_tx_sel;
  logic [CNT_W-1:0] w_tx_count_nxt;

  // r_cs_n_d resets low so that a reset released in the middle of a frame
  // (cs_n still low) is not mistaken for a new frame start.
  assign w_cs_fall = !cs_n && r_cs_n_d;
  assign w_cs_rise = cs_n && !r_cs_n_d;

  // Data byte number within the payload (byte 2 of the frame is data byte 0).
  assign w_d = r_rx_count - CNT_W'(2);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, receive decode and end-of-frame evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_state_dec    = r_state;
    w_rx_count_nxt = r_rx_count;
    w_overflow_nxt = r_overflow;
    w_word_nxt     = r_word;
    w_emit         = 1'b0;
    w_emit_value   = {rx_byte, r_word};
    w_emit_idx     = IDX_W'(w_d >> 2);
    w_snap         = 1'b0;
    w_done         = 1'b0;
    w_err          = 1'b0;

    if (r_state == S_IDLE) begin
      if (w_cs_fall) begin
        w_state_nxt    = S_OPCODE;
        w_rx_count_nxt = '0;
        w_overflow_nxt = 1'b0;
        w_word_nxt     = '0;
      end
    end else begin
      // Bytes are counted in every active state so the transmit hold-off
      // keeps moving even in discarded frames.
      if (rx_valid) begin
        w_rx_count_nxt = sat_inc(r_rx_count);
        case (r_state)
          S_OPCODE: begin
            if (rx_byte == WRITE_OPCODE) begin
              w_state_nxt = S_ADDR;
            end else if (rx_byte == READ_OPCODE) begin
              w_state_nxt = S_RDATA;
              w_snap      = 1'b1;
            end else begin
              w_state_nxt = S_DISCARD;
            end
          end
          S_ADDR: begin
            w_state_nxt = (rx_byte == BUF_ADDRESS) ? S_WDATA : S_DISCARD;
          end
          S_WDATA: begin
            if (r_rx_count < CNT_FRAME) begin
              case (w_d[1:0])
                2'd0:    w_word_nxt[7:0]   = rx_byte;
                2'd1:    w_word_nxt[15:8]  = rx_byte;
                2'd2:    w_word_nxt[23:16] = rx_byte;
                default: w_emit            = 1'b1;
              endcase
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // A byte arriving together with cs_n rising is decoded above first,
      // so the verdict below sees the final count and state.
      w_state_dec = w_state_nxt;
      if (w_cs_rise) begin
        w_state_nxt = S_IDLE;
        if ((w_state_dec == S_WDATA && w_rx_count_nxt == CNT_FRAME && !w_overflow_nxt) ||
            (w_state_dec == S_RDATA && w_rx_count_nxt == CNT_READ)) begin
          w_done = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit servicing
  // ---------------------------------------------------------------------------
  always_comb begin
    // On the frame-start cycle the counters are about to clear; use the
    // cleared values so a request landing on that cycle is byte 0.
    w_tx_base  = w_cs_fall ? '0 : r_tx_count;
    w_rx_base  = w_cs_fall ? '0 : r_rx_count;
    w_in_frame = !cs_n && (w_cs_fall || r_state != S_IDLE);

    // Byte k (k >= 1) waits until k bytes have been received, which
    // guarantees the opcode (and snapshot) is settled before byte 1 loads.
    w_tx_ready = !w_in_frame || (w_tx_base == '0) || (w_rx_base >= w_tx_base);
    w_tx_serve = tx_req && !r_tx_wren && !r_tx_served && w_tx_ready;

    w_tx_sel = 8'h00;
    if (w_in_frame && r_state == S_RDATA) begin
      case (w_tx_base)
        CNT_W'(1): w_tx_sel = r_shadow[31:24];
        CNT_W'(2): w_tx_sel = r_shadow[23:16];
        CNT_W'(3): w_tx_sel = r_shadow[15:8];
        CNT_W'(4): w_tx_sel = r_shadow[7:0];
        default:   w_tx_sel = 8'h00;
      endcase
    end

    w_tx_count_nxt = w_tx_base;
    if (w_tx_serve && w_in_frame) begin
      w_tx_count_nxt = sat_inc(w_tx_base);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n_d       <= 1'b0;
      r_rx_count     <= '0;
      r_tx_count     <= '0;
      r_overflow     <= 1'b0;
      r_word         <= '0;
      r_shadow       <= '0;
      r_sensor_value <= '0;
      r_sensor_index <= '0;
      r_sensor_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_error  <= 1'b0;
      r_tx_byte      <= '0;
      r_tx_wren      <= 1'b0;
      r_tx_served    <= 1'b0;
    end else begin
      r_cs_n_d   <= cs_n;
      r_rx_count <= w_rx_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_word     <= w_word_nxt;

      if (w_snap) begin
        r_shadow <= command_in;
      end

      r_sensor_valid <= w_emit;
      if (w_emit) begin
        r_sensor_value <= w_emit_value;
        r_sensor_index <= w_emit_idx;
      end

      r_frame_done  <= w_done;
      r_frame_error <= w_err;

      r_tx_count <= w_tx_count_nxt;
      r_tx_wren  <= w_tx_serve;
      if (w_tx_serve) begin
        r_tx_byte <= w_tx_sel;
      end

      // One load per tx_req assertion: re-arm only once the request drops.
      if (!tx_req) begin
        r_tx_served <= 1'b0;
      end else if (w_tx_serve) begin
        r_tx_served <= 1'b1;
      end
    end
  end

  assign tx_byte      = r_tx_byte;
  assign tx_wren      = r_tx_wren;
  assign sensor_value = r_sensor_value;
  assign sensor_index = r_sensor_index;
  assign sensor_valid = r_sensor_valid;
  assign frame_done   = r_frame_done;
  assign frame_error  = r_frame_error;

endmodule

// File: doc/spi_frame_responder.md
Name: spi_frame_responder

Overview:
- Slave-side peer of the sensor-frame SPI master: sits behind a byte-level SPI slave core and decodes master-initiated frames.
- Write frames deliver NUM_SENSORS 32-bit sensor values, LSB-first. Each completed value is emitted as a one-cycle strobe into the downstream sensor buffer.
- Read frames return a 32-bit command word, MSB-first, snapshotted at opcode time.

Parameters:
- NUM_SENSORS, 8, 32-bit values per write frame; frame length FRAME_LEN = 2 + 4*NUM_SENSORS (34).
- WRITE_OPCODE, 8'h02, byte 0 of a write frame.
- READ_OPCODE, 8'h00, byte 0 of a read frame.
- BUF_ADDRESS, 8'h00, only legal address byte (byte 1) of a write frame.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cs_n  in  1  chip select, already synchronised to clock; low = frame active
- rx_valid  in  1  one-cycle strobe, rx_byte holds a completed received byte
- rx_byte  in  8  received byte
- tx_req  in  1  level, slave core requests the next transmit byte
- tx_byte  out  8  byte to transmit
- tx_wren  out  1  one-cycle strobe loading tx_byte into the core
- command_in  in  32  command word returned on read frames
- sensor_value  out  32  assembled sensor value
- sensor_index  out  $clog2(NUM_SENSORS)  index of sensor_value, 0-based
- sensor_valid  out  1  one-cycle strobe, sensor_value/sensor_index valid
- frame_done  out  1  one-cycle strobe, a complete legal frame ended
- frame_error  out  1  one-cycle strobe, an illegal, short or overlong frame ended

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shadow 0. Reset mid-frame aborts the frame with no strobes; decoding resumes at the next cs_n falling edge.
- States: IDLE, OPCODE, ADDR, WDATA, RDATA, DISCARD.
- IDLE -> OPCODE on cs_n falling edge. This also clears rx_count, tx_count and the word assembler.
- OPCODE, first rx_valid:
  - WRITE_OPCODE -> ADDR.
  - READ_OPCODE -> RDATA; capture command_in into shadow in the same cycle.
  - Any other value -> DISCARD.
- ADDR: byte == BUF_ADDRESS -> WDATA; otherwise -> DISCARD.
- WDATA, data byte d = rx_count-2:
  - Stored into lane d%4 (lane 0 = bits 7:0).
  - On lane 3, sensor_valid pulses in the cycle after that rx_valid, with the full word and sensor_index = d/4.
  - rx_count saturates at FRAME_LEN+1; bytes beyond FRAME_LEN set the overflow flag and are ignored.
- RDATA: received bytes are counted and otherwise ignored.
- DISCARD: all bytes ignored until cs_n rises.
- cs_n rising edge: strobe one cycle later, then -> IDLE.
  - frame_done when either:
    - write frame with rx_count == FRAME_LEN exactly, or
    - read frame with rx_count == 5.
  - frame_error otherwise, including DISCARD, short frames, overflow, or cs_n high before any byte.
  - Never both strobes.
  - A partially assembled word in a short write frame is dropped, not emitted.
- Transmit:
  - tx_count counts bytes loaded this frame.
  - On tx_req high and tx_wren low, tx_wren pulses the next cycle with:
    - tx_count 0: 8'h00.
    - tx_count 1..4 in a read frame: shadow[31:24], [23:16], [15:8], [7:0].
    - Everything else: 8'h00.
  - For tx_count k >= 1, service is held off until rx_count >= k, so the opcode is decoded before byte 1 is loaded.
  - At most one tx_wren per tx_req assertion; tx_req must drop and re-rise for the next byte.
  - tx_req while cs_n is high is serviced with 8'h00 and does not advance tx_count.
- Simultaneous rx_valid and cs_n rising in the same cycle: the byte is counted first, then the end of frame is evaluated.
- command_in changes after the snapshot do not affect the current frame.

Test Plan:
- Write frame 02,00, then bytes 01..20 hex, cs_n rises -> 8 sensor_valid strobes, index 0 value 32'h04030201, index 7 value 32'h201F1E1D, then one frame_done, no frame_error.
- Read frame with command_in=32'hDEADBEEF at opcode time (changed to 0 right after), 5 tx_req cycles -> tx_wren bytes 00,DE,AD,BE,EF, then frame_done.
- Write frame with address 8'h05 -> no sensor_valid, frame_error at cs_n rise; a following legal frame decodes normally.
- Write frame cut after 13 bytes (11 data bytes) -> sensor_valid for indices 0,1 only, partial word 2 dropped, frame_error.
- 35-byte write frame -> all 8 values emitted, frame_error (overflow); unknown opcode 8'h7E -> frame_error, tx bytes all 00.
- reset_n pulsed low at byte 10 of a write frame -> all outputs 0 immediately, no strobes; next full frame yields 8 values and frame_done.
